// File: rtl/hilo_mdu_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/divide unit.
interface hilo_mdu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             cancel;
   logic             busy;
   logic             done;
   logic             stall_req;
   logic [WIDTH-1:0] hi_rdata;
   logic [WIDTH-1:0] lo_rdata;

   modport master (
      output start, op, src_a, src_b, cancel,
      input  busy, done, stall_req, hi_rdata, lo_rdata
   );

   modport slave (
      input  start, op, src_a, src_b, cancel,
      output busy, done, stall_req, hi_rdata, lo_rdata
   );
endinterface

// File: rtl/hilo_mdu.sv
// HI/LO register pair with an iterative shift-add multiplier and restoring divider,
// MTHI/MTLO writes, a pipeline stall request and flush cancel.
module hilo_mdu #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic      clk,
   input  logic      rst,
   hilo_mdu_if.slave bus
);
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
   state_t state_reg, state_next;

   logic [WIDTH-1:0]   hi_reg, lo_reg, opnd_reg, a_raw_reg;
   logic [2*WIDTH-1:0] prod_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               neg_q_reg, neg_r_reg, dz_reg, busy_reg, done_reg;

   logic               is_mul, is_div, is_signed, req_ok, last, neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [2*WIDTH-1:0] mul_step, div_step, mul_fin;
   logic [WIDTH-1:0]   quo, rem, hi_fin, lo_fin;

   assign is_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
   assign is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
   assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign req_ok    = (state_reg == IDLE) && bus.start && !bus.cancel;
   assign last      = (cnt_reg == CNT_W'(WIDTH - 1));
   assign neg_a     = is_signed && bus.src_a[WIDTH-1];
   assign neg_b     = is_signed && bus.src_b[WIDTH-1];
   assign mag_a     = neg_a ? -bus.src_a : bus.src_a;
   assign mag_b     = neg_b ? -bus.src_b : bus.src_b;

   // prod_reg is the multiply accumulator/multiplier, or {remainder, dividend/quotient}
   always_comb begin
      mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, opnd_reg} : '0);
      mul_step  = {mul_sum, prod_reg[WIDTH-1:1]};
      mul_fin   = neg_q_reg ? -mul_step : mul_step;
      div_trial = {prod_reg[2*WIDTH-1:WIDTH], prod_reg[WIDTH-1]} - {1'b0, opnd_reg};
      if (!div_trial[WIDTH]) begin
         div_step = {div_trial[WIDTH-1:0], prod_reg[WIDTH-2:0], 1'b1};
      end else begin
         div_step = {prod_reg[2*WIDTH-2:0], 1'b0};
      end
      quo = neg_q_reg ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
      rem = neg_r_reg ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
      if (state_reg == MUL) begin
         {hi_fin, lo_fin} = mul_fin;
      end else if (dz_reg) begin
         hi_fin = a_raw_reg;
         lo_fin = '1;
      end else begin
         hi_fin = rem;
         lo_fin = quo;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (req_ok && is_mul) begin
               state_next = MUL;
            end else if (req_ok && is_div) begin
               state_next = DIV;
            end
         end
         MUL, DIV: begin
            if (bus.cancel || last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_reg    <= '0;
         lo_reg    <= '0;
         opnd_reg  <= '0;
         a_raw_reg <= '0;
         prod_reg  <= '0;
         cnt_reg   <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         dz_reg    <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         busy_reg <= (state_next != IDLE);
         done_reg <= 1'b0;
         if (req_ok && (is_mul || is_div)) begin
            opnd_reg  <= is_mul ? mag_a : mag_b;
            prod_reg  <= {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
            a_raw_reg <= bus.src_a;
            neg_q_reg <= neg_a ^ neg_b;
            neg_r_reg <= neg_a;
            dz_reg    <= is_div && (bus.src_b == '0);
            cnt_reg   <= '0;
         end else if (state_reg != IDLE) begin
            if (bus.cancel || last) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg  <= cnt_reg + CNT_W'(1);
               prod_reg <= (state_reg == MUL) ? mul_step : div_step;
            end
            // The final iteration is folded into the commit; a flush on this edge wins.
            if (last && !bus.cancel) begin
               hi_reg   <= hi_fin;
               lo_reg   <= lo_fin;
               done_reg <= 1'b1;
            end
         end
         if (req_ok && (bus.op == OP_MTHI)) begin
            hi_reg <= bus.src_a;
         end
         if (req_ok && (bus.op == OP_MTLO)) begin
            lo_reg <= bus.src_a;
         end
      end
   end

   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.stall_req = busy_reg | (bus.start & (is_mul | is_div) & (state_reg == IDLE));
   assign bus.hi_rdata  = hi_reg;
   assign bus.lo_rdata  = lo_reg;
endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
- Parametrised successor to the plain HI/LO register pair: holds HI/LO and adds an iterative multiply/divide engine plus MTHI/MTLO writes.
- Sits in the EX stage next to the ALU; results are read by MFHI/MFLO.
- Raises a stall request to the pipeline while an operation runs; the in-flight operation can be cancelled by an exception flush.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; the product/quotient pair is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  request, sampled at rising edge.
- op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP.
- src_a  in  WIDTH  multiplicand/dividend, or MTHI/MTLO data.
- src_b  in  WIDTH  multiplier/divisor (ignored for MTHI/MTLO).
- cancel  in  1  flush; aborts the in-flight operation.
- busy  out  1  engine iterating (registered).
- done  out  1  one-cycle pulse after MULT/DIV commit (registered).
- stall_req  out  1  combinational: busy | (start & op in 001..100 & state==IDLE).
- hi_rdata  out  WIDTH  HI register.
- lo_rdata  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, any time, asynchronous): HI=0, LO=0, busy=0, done=0, state=IDLE, counter=0, operand/accumulator registers=0. This includes a multiply/divide in flight, which is lost with no done.
- States:
  - IDLE: start&MULT/MULTU -> MUL; start&DIV/DIVU -> DIV; MTHI/MTLO/NOP -> stay in IDLE.
  - MUL, DIV: counter increments each edge; on the edge where counter reaches WIDTH-1, commit and go to IDLE.
- start is honoured only in IDLE; start while busy is ignored with no queueing. The pipeline must hold because stall_req=1.
- MTHI/MTLO in IDLE: HI (resp. LO) <= src_a at the sampling edge; the other register is unchanged; busy/done stay 0; new value visible on the read port the next cycle.
- Latency: start sampled at edge k (operands latched, busy=1 after k). Iterations run on edges k+1..k+WIDTH-1, one per edge, with the last iteration folded into the commit. HI/LO are written at edge k+WIDTH. busy=1 for exactly WIDTH cycles; done=1 for the single cycle after edge k+WIDTH.
- Multiply: shift-add over operand magnitudes. Signed (MULT): the magnitudes of src_a and src_b are used, and the 2*WIDTH product is negated if sign(a)^sign(b). {HI,LO} = product.
- Divide: restoring, one quotient bit per iteration, on magnitudes. LO = quotient, HI = remainder.
  - Signed (DIV): quotient negated if sign(a)^sign(b); remainder takes the sign of the dividend (truncating division).
  - Signed MIN / -1: LO = MIN (0x80000000 at WIDTH=32), HI = 0. No trap.
  - Divide by zero (src_b=0, either signedness): the full WIDTH cycles still elapse; commit HI = src_a, LO = all ones.
- cancel:
  - While busy: at the next edge state -> IDLE, busy -> 0, no commit, HI/LO unchanged, no done.
  - On the commit edge: cancel wins; no write, no done.
  - In IDLE with start: the request is dropped (no MTHI/MTLO write, no engine start).
- Read ports always show the committed registers. There is no bypass of the in-flight result or of a same-cycle MTHI/MTLO.

Test Plan:
- Reset mid-MULT: rst=0 asynchronously at iteration 10 -> HI/LO/busy/done = 0 immediately, no done pulse after release.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> busy 32 cycles, done 1 cycle, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x1234, b=0 -> after 32 cycles HI=0x00001234, LO=0xFFFFFFFF, done pulses.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A on back-to-back cycles -> HI/LO updated the cycle after each; busy and done stay 0; a start issued during MULT is ignored and HI/LO equal only the MULT result.
- cancel at iteration 20 of DIVU 100/7, and separately cancel on the commit edge -> HI/LO keep prior values, no done, busy=0 next cycle, and a new MULT is accepted the following cycle.
